pronoc_synfull_ejector: RTL and testbench

Per-endpoint ejection buffer on the delivery side of the SynFull trace-driven NoC bench. It accepts packets that a `packet_injector` has received from the NoC. It stores each packet's `{id, size, source}` in a circular FIFO. It hands them to the SynFull DPI interface over a valid/ready handshake, so the consumer can apply real backpressure instead of a tied-high ready. It back-pressures the injector with a skid margin, counts drops on overflow, and keeps receive statistics. One instance is placed per endpoint, NE in total.

---
 rtl/pronoc_synfull_ejector_pkg.sv | 29 ++
 rtl/pronoc_synfull_ejector_if.sv | 34 +++
 rtl/pronoc_synfull_ejector_ring_buf.sv | 69 ++++++
 rtl/pronoc_synfull_ejector.sv | 151 +++++++++++++++
 tb/tb_pronoc_synfull_ejector.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pronoc_synfull_ejector_pkg.sv
// Shared types and constants for the SynFull ejection buffer.
//   NEw / PCK_SIZw : endpoint address and packet-size widths of the NoC
//   EJCT_DEPTH_DEF : default storage depth
//   ejct_entry_t   : {id, size, src} record at the default id width
//   ejct_state_e   : output-register FSM states
//   sat_inc16      : saturating 16-bit increment used by the drop counter
package pronoc_synfull_ejector_pkg;

  localparam int NEw            = 4;
  localparam int PCK_SIZw       = 6;
  localparam int EJCT_DEPTH_DEF = 16;
  localparam int EJCT_ID_W_DEF  = 32;

  typedef struct packed {
    logic [EJCT_ID_W_DEF-1:0] id;
    logic [PCK_SIZw-1:0]      size;
    logic [NEw-1:0]           src;
  } ejct_entry_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ejct_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pronoc_synfull_ejector_if.sv
// Handshake bundle between the packet injector, the ejection buffer and the
// SynFull delivery consumer.
//   rx_*  : injector -> ejector packet strobe and payload, rx_ready_o back
//   del_* : ejector -> SynFull delivery payload/valid, del_ready_i back
// Modports: slave = ejection buffer, master = injector/consumer side.
interface pronoc_synfull_ejector_if
  import pronoc_synfull_ejector_pkg::*;
#(
  parameter int ID_W = EJCT_ID_W_DEF
);

  logic                rx_wr_i;
  logic [ID_W-1:0]     rx_id_i;
  logic [PCK_SIZw-1:0] rx_size_i;
  logic [NEw-1:0]      rx_src_i;
  logic                rx_ready_o;

  logic                del_valid_o;
  logic [ID_W-1:0]     del_id_o;
  logic [PCK_SIZw-1:0] del_size_o;
  logic [NEw-1:0]      del_src_o;
  logic                del_ready_i;

  modport slave (
    input  rx_wr_i, rx_id_i, rx_size_i, rx_src_i, del_ready_i,
    output rx_ready_o, del_valid_o, del_id_o, del_size_o, del_src_o
  );

  modport master (
    output rx_wr_i, rx_id_i, rx_size_i, rx_src_i, del_ready_i,
    input  rx_ready_o, del_valid_o, del_id_o, del_size_o, del_src_o
  );

endinterface

// File: rtl/pronoc_synfull_ejector_ring_buf.sv
// Circular FIFO storage behind the ejector output register. Flat register
// array so it stays in flops; read data is the entry at the read pointer.
//   clk, rst_n     : clock, async active-low reset
//   i_push/i_wr_data : store one entry at the write pointer
//   i_pop          : advance the read pointer
//   o_rd_data      : entry at the read pointer
//   o_count        : current occupancy (0..DEPTH)
//   o_count_next   : occupancy after this edge
//   o_full/o_empty : occupancy flags
// Push and pop in the same cycle while full is legal: the write lands in the
// slot being read, and the read sees the old contents.
module pronoc_synfull_ejector_ring_buf
  import pronoc_synfull_ejector_pkg::*;
#(
  parameter int  DEPTH   = EJCT_DEPTH_DEF,
  parameter type entry_t = ejct_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  entry_t        i_wr_data,
  input  logic          i_pop,
  output entry_t        o_rd_data,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_next,
  output logic          o_full,
  output logic          o_empty
);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);

endmodule

// File: rtl/pronoc_synfull_ejector.sv
// Per-endpoint ejection buffer: takes packets from the injector, queues
// {id, size, src}, and presents them to SynFull over valid/ready. Drops and
// counts writes that find no room; keeps receive statistics.
//   clk, reset    : clock, async active-low reset
//   bus (slave)   : rx_* injector side, del_* delivery side
//   ovf_o         : one-cycle pulse per dropped packet
//   drop_cnt_o    : saturating drop count
//   rx_pck_cnt_o  : accepted packets (wraps)
//   rx_flit_cnt_o : accepted flits (wraps)
//   max_occ_o     : storage occupancy high-water mark
//   idle_o        : storage and output register both empty
//
// Output register FSM
//   state    | meaning
//   ST_EMPTY | output register empty, del_valid_o = 0
//   ST_HOLD  | output register holds an entry, del_valid_o = 1
module pronoc_synfull_ejector
  import pronoc_synfull_ejector_pkg::*;
#(
  parameter int  DEPTH = EJCT_DEPTH_DEF,
  parameter int  SKID  = 2,
  parameter int  ID_W  = EJCT_ID_W_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  pronoc_synfull_ejector_if.slave  bus,
  output logic                     ovf_o,
  output logic [15:0]              drop_cnt_o,
  output logic [63:0]              rx_pck_cnt_o,
  output logic [63:0]              rx_flit_cnt_o,
  output logic [CW-1:0]            max_occ_o,
  output logic                     idle_o
);

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [PCK_SIZw-1:0] size;
    logic [NEw-1:0]      src;
  } entry_t;

  ejct_state_e   r_state;
  entry_t        r_out;
  logic          r_ovf;
  logic [15:0]   r_drop_cnt;
  logic [63:0]   r_pck_cnt;
  logic [63:0]   r_flit_cnt;
  logic [CW-1:0] r_max_occ;

  entry_t        w_rx_entry;
  entry_t        w_rd_entry;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_free;
  logic          w_full;
  logic          w_empty;
  logic          w_xfer;
  logic          w_bypass;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  assign w_rx_entry = '{id: bus.rx_id_i, size: bus.rx_size_i, src: bus.rx_src_i};

  assign w_xfer   = (r_state == ST_HOLD) & bus.del_ready_i;
  // A write may skip storage only when the output register is (or is about
  // to become) free and nothing older is waiting in storage.
  assign w_bypass = ((r_state == ST_EMPTY) | w_xfer) & w_empty;
  // When full, a same-cycle transfer refills from storage and frees a slot.
  assign w_accept = bus.rx_wr_i & (~w_full | w_xfer | w_bypass);
  assign w_drop   = bus.rx_wr_i & ~w_accept;
  assign w_push   = w_accept & ~w_bypass;
  assign w_pop    = w_xfer & ~w_empty;

  pronoc_synfull_ejector_ring_buf #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring_buf (
    .clk          (clk),
    .rst_n        (reset),
    .i_push       (w_push),
    .i_wr_data    (w_rx_entry),
    .i_pop        (w_pop),
    .o_rd_data    (w_rd_entry),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out   <= w_rx_entry;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_xfer) begin
            if (w_pop)         r_out   <= w_rd_entry;
            else if (w_accept) r_out   <= w_rx_entry;
            else               r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_pck_cnt  <= '0;
      r_flit_cnt <= '0;
      r_max_occ  <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
      if (w_accept) begin
        r_pck_cnt  <= r_pck_cnt + 64'd1;
        r_flit_cnt <= r_flit_cnt + 64'(bus.rx_size_i);
      end
      if (w_count_next > r_max_occ) r_max_occ <= w_count_next;
    end
  end

  // Ready is held low during reset so the injector never writes into a
  // buffer that is being cleared.
  assign w_free         = CW'(DEPTH) - w_count;
  assign bus.rx_ready_o = reset & (w_free > CW'(SKID));

  assign bus.del_valid_o = (r_state == ST_HOLD);
  assign bus.del_id_o    = r_out.id;
  assign bus.del_size_o  = r_out.size;
  assign bus.del_src_o   = r_out.src;

  assign ovf_o         = r_ovf;
  assign drop_cnt_o    = r_drop_cnt;
  assign rx_pck_cnt_o  = r_pck_cnt;
  assign rx_flit_cnt_o = r_flit_cnt;
  assign max_occ_o     = r_max_occ;
  assign idle_o        = (w_count == '0) & (r_state == ST_EMPTY);

endmodule

// File: tb/tb_pronoc_synfull_ejector.sv
module tb_pronoc_synfull_ejector;
  import pronoc_synfull_ejector_pkg::*;

  localparam int DEPTH = 16;
  localparam int SKID  = 2;
  localparam int ID_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pronoc_synfull_ejector_if #(.ID_W(ID_W)) bus ();

  logic          ovf_o;
  logic [15:0]   drop_cnt_o;
  logic [63:0]   rx_pck_cnt_o;
  logic [63:0]   rx_flit_cnt_o;
  logic [CW-1:0] max_occ_o;
  logic          idle_o;

  pronoc_synfull_ejector #(.DEPTH(DEPTH), .SKID(SKID), .ID_W(ID_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .ovf_o         (ovf_o),
    .drop_cnt_o    (drop_cnt_o),
    .rx_pck_cnt_o  (rx_pck_cnt_o),
    .rx_flit_cnt_o (rx_flit_cnt_o),
    .max_occ_o     (max_occ_o),
    .idle_o        (idle_o)
  );

  // Reference model: everything held by the block (output register plus
  // storage) is one in-order queue; its head is what SynFull sees.
  typedef struct {
    logic [ID_W-1:0]     id;
    logic [PCK_SIZw-1:0] size;
    logic [NEw-1:0]      src;
  } pkt_t;

  pkt_t        q[$];
  int          m_drop;
  bit          m_ovf;
  longint      m_pck;
  longint      m_flit;
  int          m_max;
  int          checks = 0;
  int          errors = 0;

  function automatic int stored();
    return (q.size() > 0) ? q.size() - 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_ovf = 0; m_pck = 0; m_flit = 0; m_max = 0;
  endtask

  task automatic check_all();
    chk("del_valid", bus.del_valid_o, 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("del_id",   bus.del_id_o,   q[0].id);
      chk("del_size", bus.del_size_o, q[0].size);
      chk("del_src",  bus.del_src_o,  q[0].src);
    end
    chk("rx_ready", bus.rx_ready_o, 64'((DEPTH - stored()) > SKID));
    chk("idle",     idle_o,         64'(q.size() == 0));
    chk("ovf",      ovf_o,          64'(m_ovf));
    chk("drop_cnt", drop_cnt_o,     64'(m_drop));
    chk("pck_cnt",  rx_pck_cnt_o,   64'(m_pck));
    chk("flit_cnt", rx_flit_cnt_o,  64'(m_flit));
    chk("max_occ",  max_occ_o,      64'(m_max));
  endtask

  // One clock cycle: present inputs, predict, clock, update model, compare.
  task automatic step(input bit wr, input logic [ID_W-1:0] id,
                      input logic [PCK_SIZw-1:0] size, input logic [NEw-1:0] src,
                      input bit rdy);
    pkt_t p;
    bit   xfer;
    bit   acc;
    p = '{id: id, size: size, src: src};
    bus.rx_wr_i     = wr;
    bus.rx_id_i     = id;
    bus.rx_size_i   = size;
    bus.rx_src_i    = src;
    bus.del_ready_i = rdy;
    xfer = (q.size() > 0) && rdy;
    acc  = wr && ((stored() < DEPTH) || xfer);
    @(posedge clk);
    #1;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      q.push_back(p);
      m_pck++;
      m_flit += longint'(size);
    end
    m_ovf = wr && !acc;
    if (m_ovf && m_drop < 65535) m_drop++;
    if (stored() > m_max) m_max = stored();
    check_all();
  endtask

  task automatic step_rand(input bit wr, input bit rdy);
    step(wr, ID_W'($urandom), PCK_SIZw'($urandom), NEw'($urandom), rdy);
  endtask

  initial begin
    longint base;
    model_reset();
    bus.rx_wr_i = 0; bus.rx_id_i = '0; bus.rx_size_i = '0; bus.rx_src_i = '0;
    bus.del_ready_i = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", bus.rx_ready_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_valid", bus.del_valid_o, 0);
    reset = 1'b1;
    #1;
    check_all();

    // Single packet, bypass latency and idle return
    step(1, 32'h1234, 6'd5, 4'd3, 1);
    chk("s1_flit", rx_flit_cnt_o, 5);
    step(0, '0, '0, '0, 1);
    chk("s1_idle", idle_o, 1);

    // Fill with consumer stalled: 17 kept, 3 dropped
    for (int i = 1; i <= 20; i++) begin
      step(1, 32'h100 + ID_W'(i), PCK_SIZw'(1 + i % 7), NEw'(i), 0);
      if (i == 14) chk("fill_ready_hi", bus.rx_ready_o, 1);
      if (i == 15) chk("fill_ready_lo", bus.rx_ready_o, 0);
      if (i >= 18) chk("fill_ovf", ovf_o, 1);
    end
    chk("fill_drop", drop_cnt_o, 3);
    chk("fill_maxocc", max_occ_o, 16);
    chk("fill_head", bus.del_id_o, 32'h101);

    // Full storage, write and transfer in the same cycle
    step(1, 32'h200, 6'd2, 4'd9, 1);
    chk("full_rw_ovf", ovf_o, 0);
    chk("full_rw_drop", drop_cnt_o, 3);

    // Drain back-to-back
    for (int i = 0; i < 17; i++) begin
      step(0, '0, '0, '0, 1);
      if (i < 16) chk("drain_valid", bus.del_valid_o, 1);
    end
    chk("drain_idle", idle_o, 1);

    // 100-packet stream at full rate
    base = m_pck;
    for (int i = 0; i < 100; i++) step_rand(1, 1);
    step(0, '0, '0, '0, 1);
    chk("stream_pck", rx_pck_cnt_o - 64'(base), 100);

    // Random traffic with backpressure
    for (int i = 0; i < 400; i++)
      step_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    for (int i = 0; i < 20; i++) step_rand(0, 1);

    // Asynchronous reset with five entries held
    for (int i = 0; i < 5; i++) step_rand(1, 0);
    #2;
    reset = 1'b0;
    bus.rx_wr_i = 0;
    #1;
    chk("mrst_valid", bus.del_valid_o, 0);
    chk("mrst_id", bus.del_id_o, 0);
    chk("mrst_size", bus.del_size_o, 0);
    chk("mrst_src", bus.del_src_o, 0);
    chk("mrst_idle", idle_o, 1);
    chk("mrst_ready", bus.rx_ready_o, 0);
    chk("mrst_pck", rx_pck_cnt_o, 0);
    chk("mrst_flit", rx_flit_cnt_o, 0);
    chk("mrst_drop", drop_cnt_o, 0);
    chk("mrst_ovf", ovf_o, 0);
    chk("mrst_maxocc", max_occ_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(0, '0, '0, '0, 1);
    step(1, 32'hABCD, 6'd7, 4'd1, 1);
    step(0, '0, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
